// File: rtl/msb_field_sel_pipe_if.sv
// Operand/result stream bundle for msb_field_sel_pipe: producer-side pair
// handshake plus consumer-side result handshake.
interface msb_field_sel_pipe_if #(
  parameter int W = 6,
  parameter int F = 3
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         inv;
  logic         out_valid;
  logic         out_ready;
  logic [F-1:0] o;
  logic         o_src;

  modport master (
    output in_valid, x, y, inv, out_ready,
    input  in_ready, out_valid, o, o_src
  );

  modport slave (
    input  in_valid, x, y, inv, out_ready,
    output in_ready, out_valid, o, o_src
  );
endinterface

// File: rtl/msb_field_sel_pipe.sv
// Two-stage valid/ready MSB-compare field selector with per-transaction
// inversion and saturating match/mismatch event counters.
module msb_field_sel_pipe #(
  parameter int W  = 6,
  parameter int F  = 3,
  parameter int CW = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cnt_clr,
  msb_field_sel_pipe_if.slave bus,
  output logic [CW-1:0]       match_cnt,
  output logic [CW-1:0]       miss_cnt
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  logic         eq;
  logic [F-1:0] field;
  logic         s1_valid;
  logic         s1_eq;
  logic         s1_inv;
  logic [F-1:0] s1_field;
  logic         s2_valid;
  logic         s2_free;
  logic         in_fire;
  logic         s1_move;
  logic         unused_bits;

  assign eq      = (bus.x[W-1] == bus.y[W-1]);
  assign field   = eq ? bus.x[W-1 -: F] : bus.y[F-1:0];
  assign unused_bits = ^{bus.x, bus.y};

  // S2 frees up either when empty or when its result leaves this edge,
  // which lets a full pipe accept, shift and emit all at once.
  assign s2_free      = !s2_valid || bus.out_ready;
  assign bus.in_ready = !s1_valid || s2_free;
  assign in_fire      = bus.in_valid && bus.in_ready;
  assign s1_move      = s1_valid && s2_free;
  assign bus.out_valid = s2_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_eq    <= 1'b0;
      s1_inv   <= 1'b0;
      s1_field <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_eq    <= eq;
      s1_inv   <= bus.inv;
      s1_field <= field;
    end else if (s1_move) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      bus.o     <= '0;
      bus.o_src <= 1'b0;
    end else if (s1_move) begin
      s2_valid  <= 1'b1;
      bus.o     <= s1_inv ? ~s1_field : s1_field;
      bus.o_src <= s1_eq;
    end else if (s2_valid && bus.out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  // Clear wins over a coincident increment; that event is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_cnt <= '0;
      miss_cnt  <= '0;
    end else if (cnt_clr) begin
      match_cnt <= '0;
      miss_cnt  <= '0;
    end else if (in_fire) begin
      if (eq) begin
        if (match_cnt != CNT_MAX) match_cnt <= match_cnt + CW'(1);
      end else begin
        if (miss_cnt != CNT_MAX) miss_cnt <= miss_cnt + CW'(1);
      end
    end
  end

endmodule
